// File: rtl/alu_op_encoder_if.sv
// Request/response bundle between the decode stage, the ALU op encoder and the ALU.
//   master : decode-side driver (request in, ALU-side consume, observes status)
//   slave  : the encoder itself
// Signals:
//   in_valid/in_ready/in_modEnable/in_shamt        request handshake and payload
//   out_valid/out_ready/ctrl_ALUopcode/ctrl_shiftamt  head-of-FIFO handshake and payload
//   err_illegal/illegal_count                      illegal-request pulse and saturating count
interface alu_op_encoder_if #(
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         in_modEnable;
  logic [4:0]         in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         ctrl_ALUopcode;
  logic [4:0]         ctrl_shiftamt;
  logic               err_illegal;
  logic [COUNT_W-1:0] illegal_count;

  modport master (
    output in_valid, in_modEnable, in_shamt, out_ready,
    input  in_ready, out_valid, ctrl_ALUopcode, ctrl_shiftamt, err_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_modEnable, in_shamt, out_ready,
    output in_ready, out_valid, ctrl_ALUopcode, ctrl_shiftamt, err_illegal, illegal_count
  );
endinterface

// File: rtl/alu_op_encoder.sv
// Converts one-hot module-select requests (ADD, SUB, AND, OR, SLL, SRA) into a
// 5-bit ALU opcode plus shift amount, buffered through a 2-entry in-order FIFO.
// Non-one-hot requests are consumed, flagged for one cycle and counted.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_op_encoder_if slave modport (request side, ALU side, error status)
module alu_op_encoder #(
  parameter int COUNT_W = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_op_encoder_if.slave bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [4:0]         op_q [2];
  logic [4:0]         op_d [2];
  logic [4:0]         sh_q [2];
  logic [4:0]         sh_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic       legal;
  logic       accept;
  logic       push;
  logic       pop;
  logic [4:0] enc_op;
  logic [4:0] enc_sh;

  // Encoding is the bit position of the single set select bit.
  always_comb begin
    enc_op = 5'd0;
    case (bus.in_modEnable)
      6'b000001: enc_op = 5'd0;
      6'b000010: enc_op = 5'd1;
      6'b000100: enc_op = 5'd2;
      6'b001000: enc_op = 5'd3;
      6'b010000: enc_op = 5'd4;
      6'b100000: enc_op = 5'd5;
      default:   enc_op = 5'd0;
    endcase
  end

  assign legal  = $onehot(bus.in_modEnable);
  assign enc_sh = (bus.in_modEnable[4] | bus.in_modEnable[5]) ? bus.in_shamt : 5'd0;

  // Ready depends only on occupancy so the upstream never sees a path from out_ready.
  assign bus.in_ready  = (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & legal;
  assign pop    = bus.out_valid & bus.out_ready;

  assign bus.ctrl_ALUopcode = bus.out_valid ? op_q[rd_ptr_q] : 5'd0;
  assign bus.ctrl_shiftamt  = bus.out_valid ? sh_q[rd_ptr_q] : 5'd0;
  assign bus.err_illegal    = err_q;
  assign bus.illegal_count  = cnt_q;

  always_comb begin
    op_d     = op_q;
    sh_d     = sh_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q;
    if (push) begin
      op_d[wr_ptr_q] = enc_op;
      sh_d[wr_ptr_q] = enc_sh;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    err_d = accept & ~legal;
    cnt_d = (err_d && (cnt_q != CNT_MAX)) ? cnt_q + COUNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '{default: 5'd0};
      sh_q     <= '{default: 5'd0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      sh_q     <= sh_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
module tb_alu_op_encoder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_op_encoder_if #(.COUNT_W(8)) ia ();
  alu_op_encoder_if #(.COUNT_W(2)) ib ();

  alu_op_encoder #(.COUNT_W(8)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia.slave));
  alu_op_encoder #(.COUNT_W(2)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib.slave));

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a: a queue of pending {opcode, shamt} entries.
  logic [4:0] mq_op [$];
  logic [4:0] mq_sh [$];
  bit         m_err;
  int         m_cnt;
  bit         m_last_acc;

  typedef struct {
    logic [5:0] me;
    logic [4:0] sh;
    logic [4:0] exp_op;
    logic [4:0] exp_sh;
    bit         exp_legal;
  } vec_t;

  vec_t vt [13];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sel_index(logic [5:0] me);
    for (int i = 0; i < 6; i++) if (me[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    mq_op.delete();
    mq_sh.delete();
    m_err = 0;
    m_cnt = 0;
    m_last_acc = 0;
  endtask

  // Advance one clock and apply the request/consume rules to the model.
  task automatic tick();
    bit acc, pop, leg;
    int idx;
    acc = ia.in_valid && (mq_op.size() < 2);
    pop = (mq_op.size() != 0) && ia.out_ready;
    leg = ($countones(ia.in_modEnable) == 1);
    idx = sel_index(ia.in_modEnable);
    @(posedge clock);
    #1;
    if (pop) begin
      void'(mq_op.pop_front());
      void'(mq_sh.pop_front());
    end
    if (acc && leg) begin
      mq_op.push_back(5'(idx));
      mq_sh.push_back((idx >= 4) ? ia.in_shamt : 5'd0);
    end
    m_err = acc && !leg;
    if (m_err && m_cnt < 255) m_cnt++;
    m_last_acc = acc;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".in_ready"},  32'(ia.in_ready),  32'(mq_op.size() < 2));
    chk({tag, ".out_valid"}, 32'(ia.out_valid), 32'(mq_op.size() != 0));
    chk({tag, ".opcode"},    32'(ia.ctrl_ALUopcode), (mq_op.size() != 0) ? 32'(mq_op[0]) : 32'd0);
    chk({tag, ".shamt"},     32'(ia.ctrl_shiftamt),  (mq_sh.size() != 0) ? 32'(mq_sh[0]) : 32'd0);
    chk({tag, ".err"},       32'(ia.err_illegal),    32'(m_err));
    chk({tag, ".count"},     32'(ia.illegal_count),  32'(m_cnt));
  endtask

  initial begin
    logic [4:0] exp_seq [3];
    int base_cnt;

    vt[0]  = '{6'b000001, 5'd3,  5'd0, 5'd0,  1'b1};
    vt[1]  = '{6'b000010, 5'd0,  5'd1, 5'd0,  1'b1};
    vt[2]  = '{6'b000100, 5'd12, 5'd2, 5'd0,  1'b1};
    vt[3]  = '{6'b001000, 5'd1,  5'd3, 5'd0,  1'b1};
    vt[4]  = '{6'b010000, 5'd0,  5'd4, 5'd0,  1'b1};
    vt[5]  = '{6'b100000, 5'd31, 5'd5, 5'd31, 1'b1};
    vt[6]  = '{6'b010000, 5'd7,  5'd4, 5'd7,  1'b1};
    vt[7]  = '{6'b000001, 5'd9,  5'd0, 5'd0,  1'b1};
    vt[8]  = '{6'b000000, 5'd4,  5'd0, 5'd0,  1'b0};
    vt[9]  = '{6'b000011, 5'd4,  5'd0, 5'd0,  1'b0};
    vt[10] = '{6'b110000, 5'd4,  5'd0, 5'd0,  1'b0};
    vt[11] = '{6'b111111, 5'd4,  5'd0, 5'd0,  1'b0};
    vt[12] = '{6'b100000, 5'd16, 5'd5, 5'd16, 1'b1};

    ia.in_valid = 0; ia.in_modEnable = '0; ia.in_shamt = '0; ia.out_ready = 0;
    ib.in_valid = 0; ib.in_modEnable = '0; ib.in_shamt = '0; ib.out_ready = 1;
    model_clear();

    // Reset state
    #12;
    chk("rst.out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst.opcode",    32'(ia.ctrl_ALUopcode), 32'd0);
    chk("rst.shamt",     32'(ia.ctrl_shiftamt), 32'd0);
    chk("rst.err",       32'(ia.err_illegal), 32'd0);
    chk("rst.count",     32'(ia.illegal_count), 32'd0);
    chk("rst.in_ready",  32'(ia.in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1;

    // Table-driven single requests, one cycle latency, drained each time.
    ia.out_ready = 1;
    for (int i = 0; i < 13; i++) begin
      ia.in_valid = 1; ia.in_modEnable = vt[i].me; ia.in_shamt = vt[i].sh;
      tick();
      check_model($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), 32'(ia.out_valid), 32'(vt[i].exp_legal));
      chk($sformatf("vec%0d.err", i),   32'(ia.err_illegal), 32'(!vt[i].exp_legal));
      if (vt[i].exp_legal) begin
        chk($sformatf("vec%0d.op", i), 32'(ia.ctrl_ALUopcode), 32'(vt[i].exp_op));
        chk($sformatf("vec%0d.sh", i), 32'(ia.ctrl_shiftamt),  32'(vt[i].exp_sh));
      end
      ia.in_valid = 0;
      tick();
      check_model($sformatf("vec%0d.drain", i));
    end

    // Backpressure: ADD, SUB fill the FIFO, OR is held until space opens.
    ia.out_ready = 0;
    ia.in_valid = 1; ia.in_modEnable = 6'b000001; ia.in_shamt = 5'd0;
    tick(); check_model("bp.add");
    ia.in_modEnable = 6'b000010;
    tick(); check_model("bp.sub");
    chk("bp.full_ready", 32'(ia.in_ready), 32'd0);
    ia.in_modEnable = 6'b001000;
    tick(); tick(); check_model("bp.hold");
    chk("bp.hold_op", 32'(ia.ctrl_ALUopcode), 32'd0);
    ia.out_ready = 1;
    exp_seq[0] = 5'd1; exp_seq[1] = 5'd3;
    tick(); check_model("bp.pop1");
    chk("bp.pop1_op", 32'(ia.ctrl_ALUopcode), 32'(exp_seq[0]));
    chk("bp.ready_back", 32'(ia.in_ready), 32'd1);
    tick(); check_model("bp.pop2");
    chk("bp.pop2_op", 32'(ia.ctrl_ALUopcode), 32'(exp_seq[1]));
    ia.in_valid = 0;
    tick(); check_model("bp.empty");
    chk("bp.empty_valid", 32'(ia.out_valid), 32'd0);

    // Back-to-back illegal requests keep err_illegal high.
    base_cnt = int'(ia.illegal_count);
    ia.in_valid = 1; ia.in_modEnable = 6'b000000;
    tick(); check_model("ill.1");
    chk("ill.1.err", 32'(ia.err_illegal), 32'd1);
    ia.in_modEnable = 6'b000011;
    tick(); check_model("ill.2");
    chk("ill.2.err", 32'(ia.err_illegal), 32'd1);
    chk("ill.2.count", 32'(ia.illegal_count), 32'(base_cnt + 2));
    chk("ill.2.valid", 32'(ia.out_valid), 32'd0);
    ia.in_valid = 0;
    tick(); check_model("ill.3");
    chk("ill.3.err", 32'(ia.err_illegal), 32'd0);

    // Saturation with a 2-bit counter.
    exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd3;
    ib.in_valid = 1; ib.in_modEnable = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat%0d.count", i), 32'(ib.illegal_count), (i < 3) ? 32'(exp_seq[i]) : 32'd3);
      chk($sformatf("sat%0d.err", i), 32'(ib.err_illegal), 32'd1);
    end
    ib.in_valid = 0;
    tick();
    chk("sat.err_off", 32'(ib.err_illegal), 32'd0);

    // Randomized traffic against the queue model, honouring the hold rule.
    for (int c = 0; c < 400; c++) begin
      if (!(ia.in_valid && !m_last_acc)) begin
        ia.in_valid = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 9) < 8) ia.in_modEnable = 6'(1 << $urandom_range(0, 5));
        else ia.in_modEnable = 6'($urandom);
        ia.in_shamt = 5'($urandom);
      end
      ia.out_ready = ($urandom_range(0, 99) < 65);
      tick();
      check_model("rnd");
    end

    // Asynchronous reset with a full FIFO.
    ia.in_valid = 0; ia.out_ready = 0;
    tick();
    ia.in_valid = 1; ia.in_modEnable = 6'b000100; ia.in_shamt = 5'd0;
    tick();
    ia.in_modEnable = 6'b001000;
    tick();
    while (mq_op.size() < 2) begin
      ia.in_modEnable = 6'b000010;
      tick();
    end
    chk("mr.full", 32'(ia.in_ready), 32'd0);
    ia.in_valid = 0;
    #2;
    reset_n = 0;
    #1;
    model_clear();
    chk("mr.out_valid", 32'(ia.out_valid), 32'd0);
    chk("mr.opcode",    32'(ia.ctrl_ALUopcode), 32'd0);
    chk("mr.in_ready",  32'(ia.in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1;
    ia.out_ready = 1;
    ia.in_valid = 1; ia.in_modEnable = 6'b100000; ia.in_shamt = 5'd5;
    tick(); check_model("mr.new");
    chk("mr.new_op", 32'(ia.ctrl_ALUopcode), 32'd5);
    chk("mr.new_sh", 32'(ia.ctrl_shiftamt), 32'd5);
    ia.in_valid = 0;
    tick(); check_model("mr.alone");
    chk("mr.alone_valid", 32'(ia.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
